t_ff_counter: RTL



---
 rtl/t_ff_counter.sv | 114 +++++++++++
 1 files changed

// File: rtl/t_ff_counter.sv
// ==== t_ff_counter : multi-bit toggle register / modulo up-down counter with parallel load (Rev 1.0) ====
// Optional build macro TFF_CNT_SATURATE_EN: counts clamp at 0 / MOD-1 instead of wrapping.
`default_nettype none

module t_ff_counter #(
  parameter int WIDTH     = 8,
  parameter int MOD       = 256,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             err
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_UP     = 2'b10;
  localparam logic [1:0] MODE_DOWN   = 2'b11;

  // One extra bit so that MOD = 2**WIDTH is representable for range checks.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

`ifdef TFF_CNT_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  logic [WIDTH-1:0] toggled;
  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic             err_next;
  logic             at_max;
  logic             at_zero;
  logic             din_ok;
  logic             toggled_ok;

  assign toggled    = q ^ t;
  assign at_max     = (q == MAX_VAL);
  assign at_zero    = (q == '0);
  assign din_ok     = ({1'b0, din} < MOD_EXT);
  assign toggled_ok = ({1'b0, toggled} < MOD_EXT);

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    err_next  = 1'b0;
    if (load) begin
      if (din_ok) begin
        q_next = din;
      end else begin
        q_next   = MAX_VAL;
        err_next = 1'b1;
      end
    end else if (en) begin
      case (mode)
        MODE_HOLD: begin
          q_next = q;
        end
        MODE_TOGGLE: begin
          // Out-of-range toggle results are rejected; q keeps its old value.
          if (toggled_ok) begin
            q_next = toggled;
          end else begin
            err_next = 1'b1;
          end
        end
        MODE_UP: begin
          if (at_max) begin
            wrap_next = 1'b1;
            q_next    = SATURATE ? q : '0;
          end else begin
            q_next = q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (at_zero) begin
            wrap_next = 1'b1;
            q_next    = SATURATE ? q : MAX_VAL;
          end else begin
            q_next = q - WIDTH'(1);
          end
        end
        default: begin
          q_next = q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q    <= RST_Q;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
      err  <= err_next;
    end
  end

endmodule

`default_nettype wire
